alu_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared 16-bit ALU. It accepts operation requests from two requesters (port 0 and port 1) and grants them round-robin. It registers the winning operands onto the ALU inputs, holds them for a fixed number of cycles that depends on the operation, then captures the ALU result and zero flag and returns them to the requester. It sits between the ALU and its clients, such as the main datapath and an auxiliary address/compute unit.

---
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer for the shared 16-bit ALU: grants one request,
// holds its operands on the ALU for an op-dependent latency, then returns the result.
module alu_arbiter #(
   parameter int MULDIV_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic [4:0]  shamt0,
   input  logic [5:0]  funct0,
   input  logic [1:0]  aluop0,
   input  logic        req1,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic [4:0]  shamt1,
   input  logic [5:0]  funct1,
   input  logic [1:0]  aluop1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] res0,
   output logic [31:0] res1,
   output logic        zero0,
   output logic        zero1,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_shamt,
   output logic [5:0]  alu_funct,
   output logic [1:0]  alu_aluop,
   input  logic [31:0] alu_out,
   input  logic        alu_zero
);

   localparam logic [5:0] FUNCT_MUL  = 6'b011000;
   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [3:0] LAT_MULDIV = 4'(MULDIV_LAT);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  cnt;
   logic        last;
   logic        grant_fire;
   logic        winner;
   logic        finish;
   logic [15:0] sel_a;
   logic [15:0] sel_b;
   logic [4:0]  sel_shamt;
   logic [5:0]  sel_funct;
   logic [1:0]  sel_aluop;

   function automatic logic [3:0] op_latency(input logic [1:0] aluop,
                                             input logic [5:0] funct);
      if (aluop == 2'b10 && (funct == FUNCT_MUL || funct == FUNCT_DIV))
         return LAT_MULDIV;
      return 4'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req0 || req1) state_next = EXEC;
         EXEC:    if (cnt <= 4'd1) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // On a tie the port that did not win last time gets the ALU.
   always_comb begin
      grant_fire = (state == IDLE) && (req0 || req1);
      winner     = (req0 && req1) ? ~last : req1;
      finish     = (state == EXEC) && (cnt <= 4'd1);
      if (winner) begin
         sel_a     = a1;
         sel_b     = b1;
         sel_shamt = shamt1;
         sel_funct = funct1;
         sel_aluop = aluop1;
      end else begin
         sel_a     = a0;
         sel_b     = b0;
         sel_shamt = shamt0;
         sel_funct = funct0;
         sel_aluop = aluop0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= 4'd0;
         last <= 1'b1;
      end else if (grant_fire) begin
         cnt  <= op_latency(sel_aluop, sel_funct);
         last <= winner;
      end else if (state == EXEC) begin
         cnt  <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a     <= 16'd0;
         alu_b     <= 16'd0;
         alu_shamt <= 5'd0;
         alu_funct <= 6'd0;
         alu_aluop <= 2'd0;
      end else if (grant_fire) begin
         alu_a     <= sel_a;
         alu_b     <= sel_b;
         alu_shamt <= sel_shamt;
         alu_funct <= sel_funct;
         alu_aluop <= sel_aluop;
      end
   end

   // While in EXEC, last identifies the port that owns the ALU.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         res0  <= 32'd0;
         res1  <= 32'd0;
         zero0 <= 1'b0;
         zero1 <= 1'b0;
      end else begin
         gnt0  <= grant_fire && !winner;
         gnt1  <= grant_fire && winner;
         done0 <= finish && !last;
         done1 <= finish && last;
         if (finish && !last) begin
            res0  <= alu_out;
            zero0 <= alu_zero;
         end
         if (finish && last) begin
            res1  <= alu_out;
            zero1 <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the alu_* bus.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [15:0] a0, b0, a1, b1;
   logic [4:0]  shamt0, shamt1;
   logic [5:0]  funct0, funct1;
   logic [1:0]  aluop0, aluop1;
   logic        gnt0, gnt1, done0, done1;
   logic [31:0] res0, res1;
   logic        zero0, zero1;
   logic [15:0] alu_a, alu_b;
   logic [4:0]  alu_shamt;
   logic [5:0]  alu_funct;
   logic [1:0]  alu_aluop;
   logic [31:0] alu_out;
   logic        alu_zero;

   int n_cmp = 0;
   int n_err = 0;

   alu_arbiter #(.MULDIV_LAT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .shamt0(shamt0), .funct0(funct0), .aluop0(aluop0),
      .req1(req1), .a1(a1), .b1(b1), .shamt1(shamt1), .funct1(funct1), .aluop1(aluop1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .res0(res0), .res1(res1), .zero0(zero0), .zero1(zero1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
      .alu_aluop(alu_aluop), .alu_out(alu_out), .alu_zero(alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the shared ALU.
   always_comb begin
      alu_out = 32'd0;
      case (alu_aluop)
         2'b00: alu_out = {16'd0, alu_a} + {16'd0, alu_b};
         2'b01: alu_out = {16'd0, alu_a} - {16'd0, alu_b};
         2'b10: begin
            case (alu_funct)
               6'b011000: alu_out = {16'd0, alu_a} * {16'd0, alu_b};
               6'b011010: alu_out = (alu_b == 16'd0) ? 32'd0 : {16'd0, alu_a} / {16'd0, alu_b};
               6'b100000: alu_out = {16'd0, alu_a} + {16'd0, alu_b};
               default:   alu_out = 32'd0;
            endcase
         end
         default: alu_out = 32'd0;
      endcase
      alu_zero = (alu_out == 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0 = 1'b1; a0 = 16'd1; b0 = 16'd2; shamt0 = 5'd0; funct0 = 6'd0; aluop0 = 2'b00;
      req1 = 1'b0; a1 = 16'd0; b1 = 16'd0; shamt1 = 5'd0; funct1 = 6'd0; aluop1 = 2'b00;
      tick();
      tick();
      n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b required 0000", {gnt0, gnt1, done0, done1}); end
      n_cmp++; if (res0 !== 32'd0 || res1 !== 32'd0 || zero0 !== 1'b0 || zero1 !== 1'b0) begin n_err++; $display("FAIL reset_res: got res0=%0h res1=%0h z0=%b z1=%b required 0", res0, res1, zero0, zero1); end
      n_cmp++; if ({alu_a, alu_b, alu_shamt, alu_funct, alu_aluop} !== 45'd0) begin n_err++; $display("FAIL reset_alu_bus: got %0h required 0", {alu_a, alu_b, alu_shamt, alu_funct, alu_aluop}); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_first_gnt: got gnt0=%b gnt1=%b required 1/0", gnt0, gnt1); end
      req0 = 1'b0;
      tick();
      n_cmp++; if (done0 !== 1'b1 || res0 !== 32'd3) begin n_err++; $display("FAIL reset_first_done: got done0=%b res0=%0d required 1/3", done0, res0); end
      tick();
   endtask

   task automatic test_single_add();
      logic [31:0] res1_before;
      res1_before = res1;
      req0 = 1'b1; a0 = 16'd7; b0 = 16'd5; aluop0 = 2'b00; funct0 = 6'd0; shamt0 = 5'd0;
      tick();
      n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_err++; $display("FAIL add_gnt: got gnt0=%b gnt1=%b required 1/0", gnt0, gnt1); end
      n_cmp++; if (alu_a !== 16'd7 || alu_b !== 16'd5 || alu_aluop !== 2'b00) begin n_err++; $display("FAIL add_alu_bus: got a=%0d b=%0d op=%b required 7/5/00", alu_a, alu_b, alu_aluop); end
      n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL add_early_done: got %b required 0", done0); end
      req0 = 1'b0;
      tick();
      n_cmp++; if (done0 !== 1'b1 || gnt0 !== 1'b0) begin n_err++; $display("FAIL add_done: got done0=%b gnt0=%b required 1/0", done0, gnt0); end
      n_cmp++; if (res0 !== 32'd12 || zero0 !== 1'b0) begin n_err++; $display("FAIL add_res: got res0=%0d zero0=%b required 12/0", res0, zero0); end
      n_cmp++; if (res1 !== res1_before || done1 !== 1'b0) begin n_err++; $display("FAIL add_res1_kept: got res1=%0h done1=%b required %0h/0", res1, done1, res1_before); end
      tick();
      n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL add_done_width: got %b required 0", done0); end
   endtask

   task automatic test_zero_flag();
      req1 = 1'b1; a1 = 16'h1234; b1 = 16'h1234; aluop1 = 2'b01; funct1 = 6'd0; shamt1 = 5'd0;
      tick();
      n_cmp++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_err++; $display("FAIL zero_gnt: got gnt1=%b gnt0=%b required 1/0", gnt1, gnt0); end
      req1 = 1'b0;
      tick();
      n_cmp++; if (done1 !== 1'b1 || res1 !== 32'd0 || zero1 !== 1'b1) begin n_err++; $display("FAIL zero_done: got done1=%b res1=%0h zero1=%b required 1/0/1", done1, res1, zero1); end
      n_cmp++; if (res0 !== 32'd12 || zero0 !== 1'b0) begin n_err++; $display("FAIL zero_res0_kept: got res0=%0d required 12", res0); end
      tick();
      n_cmp++; if (alu_a !== 16'h1234 || alu_aluop !== 2'b01) begin n_err++; $display("FAIL zero_idle_hold: got a=%0h op=%b required 1234/01", alu_a, alu_aluop); end
   endtask

   task automatic test_mul();
      req0 = 1'b1; a0 = 16'd300; b0 = 16'd200; aluop0 = 2'b10; funct0 = 6'b011000; shamt0 = 5'd3;
      tick();
      n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL mul_gnt: got %b required 1", gnt0); end
      req0 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == 2) begin
            req1 = 1'b1; a1 = 16'd10; b1 = 16'd20; aluop1 = 2'b00; funct1 = 6'd0; shamt1 = 5'd0;
         end
         tick();
         n_cmp++; if (done0 !== 1'b0 || gnt1 !== 1'b0 || gnt0 !== 1'b0) begin n_err++; $display("FAIL mul_busy_%0d: got done0=%b gnt0=%b gnt1=%b required 0/0/0", k, done0, gnt0, gnt1); end
         n_cmp++; if (alu_a !== 16'd300 || alu_b !== 16'd200 || alu_funct !== 6'b011000 || alu_shamt !== 5'd3 || alu_aluop !== 2'b10) begin n_err++; $display("FAIL mul_bus_stable_%0d: got a=%0d b=%0d f=%b s=%0d required 300/200/011000/3", k, alu_a, alu_b, alu_funct, alu_shamt); end
      end
      tick();
      n_cmp++; if (done0 !== 1'b1 || res0 !== 32'd60000 || zero0 !== 1'b0) begin n_err++; $display("FAIL mul_done: got done0=%b res0=%0d required 1/60000", done0, res0); end
      n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL mul_gnt1_early: got %b required 0", gnt1); end
      tick();
      n_cmp++; if (gnt1 !== 1'b1 || done0 !== 1'b0) begin n_err++; $display("FAIL mul_pending_gnt1: got gnt1=%b done0=%b required 1/0", gnt1, done0); end
      req1 = 1'b0;
      tick();
      n_cmp++; if (done1 !== 1'b1 || res1 !== 32'd30) begin n_err++; $display("FAIL mul_pending_done1: got done1=%b res1=%0d required 1/30", done1, res1); end
   endtask

   task automatic test_contention();
      logic exp_port;
      req0 = 1'b1; a0 = 16'd100; b0 = 16'd1; aluop0 = 2'b00; funct0 = 6'd0; shamt0 = 5'd0;
      req1 = 1'b1; a1 = 16'd200; b1 = 16'd2; aluop1 = 2'b00; funct1 = 6'd0; shamt1 = 5'd0;
      exp_port = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++; if ({gnt1, gnt0} !== (exp_port ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_gnt_%0d: got gnt1,gnt0=%b%b required port %0d", k, gnt1, gnt0, exp_port); end
         tick();
         if (exp_port == 1'b0) begin
            n_cmp++; if (done0 !== 1'b1 || done1 !== 1'b0 || res0 !== 32'd101) begin n_err++; $display("FAIL rr_done_%0d: got done0=%b done1=%b res0=%0d required 1/0/101", k, done0, done1, res0); end
         end else begin
            n_cmp++; if (done1 !== 1'b1 || done0 !== 1'b0 || res1 !== 32'd202) begin n_err++; $display("FAIL rr_done_%0d: got done1=%b done0=%b res1=%0d required 1/0/202", k, done1, done0, res1); end
         end
         n_cmp++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_err++; $display("FAIL rr_gnt_width_%0d: got %b%b required 00", k, gnt1, gnt0); end
         exp_port = ~exp_port;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin n_err++; $display("FAIL rr_quiet: got %b required 0000", {gnt0, gnt1, done0, done1}); end
   endtask

   task automatic test_reset_mid_exec();
      req0 = 1'b1; a0 = 16'd1000; b0 = 16'd10; aluop0 = 2'b10; funct0 = 6'b011010; shamt0 = 5'd0;
      tick();
      n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL div_gnt: got %b required 1", gnt0); end
      req0 = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (done0 !== 1'b0 || res0 !== 32'd0 || res1 !== 32'd0 || alu_a !== 16'd0) begin n_err++; $display("FAIL abort_clear: got done0=%b res0=%0d res1=%0d alu_a=%0d required 0", done0, res0, res1, alu_a); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (done0 !== 1'b0 || gnt0 !== 1'b0 || res0 !== 32'd0) begin n_err++; $display("FAIL abort_no_done: got done0=%b gnt0=%b res0=%0d required 0", done0, gnt0, res0); end
      req1 = 1'b1; a1 = 16'd5; b1 = 16'd3; aluop1 = 2'b01; funct1 = 6'd0; shamt1 = 5'd0;
      tick();
      n_cmp++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_err++; $display("FAIL abort_fresh_gnt1: got gnt1=%b gnt0=%b required 1/0", gnt1, gnt0); end
      req1 = 1'b0;
      tick();
      n_cmp++; if (done1 !== 1'b1 || res1 !== 32'd2 || zero1 !== 1'b0 || res0 !== 32'd0) begin n_err++; $display("FAIL abort_fresh_done1: got done1=%b res1=%0d res0=%0d required 1/2/0", done1, res1, res0); end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_zero_flag();
      test_mul();
      test_contention();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
